// File: rtl/uart_rx_if.sv
// Receive-side bus: line/handshake inputs from the consumer and the received byte with its status flags.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_enable;
  logic                 rx_in;
  logic                 uld_rx_data;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_empty;
  logic                 rx_over_run;
  logic                 rx_frame_err;

  modport master (
    output rx_enable, rx_in, uld_rx_data,
    input  rx_data, rx_empty, rx_over_run, rx_frame_err
  );

  modport slave (
    input  rx_enable, rx_in, uld_rx_data,
    output rx_data, rx_empty, rx_over_run, rx_frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampled UART receiver: start/stop checking, LSB-first assembly,
// load/unload handshake with sticky overrun and framing-error flags.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input logic      rxclk,
  input logic      reset_n,
  uart_rx_if.slave bus
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [CW-1:0] HALF     = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic                 sync1, rx_s;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_hit, load, frame_bad;

  assign stop_hit  = bus.rx_enable && (state == STOP) && (cnt == LAST);
  assign load      = stop_hit && rx_s;
  assign frame_bad = stop_hit && !rx_s;

  // Two-flop synchronizer, preset to idle-high so reset never fakes a start edge.
  always_ff @(posedge rxclk) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= bus.rx_in;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge rxclk) begin
    if (!reset_n || !bus.rx_enable) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      if (!reset_n) shreg <= '0;
    end else begin
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          cnt   <= '0;
        end
        START: if (cnt == HALF) begin
          // A high line at mid start bit is a glitch, not a frame.
          if (!rx_s) begin
            state <= DATA;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            state <= IDLE;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        DATA: if (cnt == LAST) begin
          shreg[idx] <= rx_s;
          cnt        <= '0;
          if (idx == IDX_LAST) state <= STOP;
          else                 idx   <= idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: if (cnt == LAST) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      endcase
    end
  end

  // Loads and flag sets take priority over a same-cycle unload.
  always_ff @(posedge rxclk) begin
    if (!reset_n) begin
      bus.rx_data      <= '0;
      bus.rx_empty     <= 1'b1;
      bus.rx_over_run  <= 1'b0;
      bus.rx_frame_err <= 1'b0;
    end else begin
      if (load) begin
        bus.rx_data  <= shreg;
        bus.rx_empty <= 1'b0;
      end else if (bus.uld_rx_data) begin
        bus.rx_empty <= 1'b1;
      end

      if (load && !bus.rx_empty && !bus.uld_rx_data) bus.rx_over_run <= 1'b1;
      else if (bus.uld_rx_data)                       bus.rx_over_run <= 1'b0;

      if (frame_bad)            bus.rx_frame_err <= 1'b1;
      else if (bus.uld_rx_data) bus.rx_frame_err <= 1'b0;
    end
  end
endmodule
